// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline register with valid/ready handshake, a
//               one-entry skid buffer behind a registered in_ready, and a
//               synchronous flush that turns the stage into a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W         = 6,
    parameter int RW_W           = 5,
    parameter int DATA_W         = 32,
    parameter int NUM_CH         = 3,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RW_W-1:0]          in_rw,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [RW_W-1:0]          out_rw,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
);

    localparam int C_PAY_W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_in_ready;

    logic [CTRL_W-1:0]    r_main_ctrl;
    logic [RW_W-1:0]      r_main_rw;
    logic [C_PAY_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]    r_skid_ctrl;
    logic [RW_W-1:0]      r_skid_rw;
    logic [C_PAY_W-1:0]   r_skid_data;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_load_main_in;
    logic                 w_load_main_skid;
    logic                 w_load_skid;
    logic                 w_drain;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & out_ready;

    // State register; in_ready is precomputed from the next state so it is a flop
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Next-state decode and datapath load enables; flush overrides the handshake
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_drain          = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid  = 1'b1;
                        w_next_state = ST_FULL;
                    end else if (w_out_fire) begin
                        w_drain      = 1'b1;
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = ST_HALF;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // Head entry; ctrl is forced to zero whenever the stage holds nothing
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_main_ctrl <= '0;
            r_main_rw   <= '0;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            if (CLEAR_ON_FLUSH != 0) begin
                r_main_rw   <= '0;
                r_main_data <= '0;
            end
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_rw   <= in_rw;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_rw   <= r_skid_rw;
            r_main_data <= r_skid_data;
        end else if (w_drain) begin
            r_main_ctrl <= '0;
        end
    end

    // Skid entry catches the beat accepted while the head is stalled
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_skid_ctrl <= '0;
            r_skid_rw   <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_rw   <= in_rw;
            r_skid_data <= in_data;
        end
    end

    // Occupancy follows directly from the state encoding
    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            ST_HALF: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = r_main_ctrl;
    assign out_rw    = r_main_rw;
    assign out_data  = r_main_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed and randomized self-checking bench for pipe_stage_reg
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic reset;

    // Instance A: default widths, payload cleared on flush
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [5:0]  a_in_ctrl, a_out_ctrl;
    logic [4:0]  a_in_rw, a_out_rw;
    logic [95:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    // Instance B: four 16-bit channels, random traffic
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [5:0]  b_in_ctrl, b_out_ctrl;
    logic [4:0]  b_in_rw, b_out_rw;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    // Instance C: default widths, payload retained on flush
    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [5:0]  c_in_ctrl, c_out_ctrl;
    logic [4:0]  c_in_rw, c_out_rw;
    logic [95:0] c_in_data, c_out_data;
    logic [1:0]  c_occ;

    pipe_stage_reg #(.CTRL_W(6), .RW_W(5), .DATA_W(32), .NUM_CH(3), .CLEAR_ON_FLUSH(1)) u_dut_a (
        .CLK(CLK), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_rw(a_in_rw), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_rw(a_out_rw),
        .out_data(a_out_data), .occupancy(a_occ));

    pipe_stage_reg #(.CTRL_W(6), .RW_W(5), .DATA_W(16), .NUM_CH(4), .CLEAR_ON_FLUSH(1)) u_dut_b (
        .CLK(CLK), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_rw(b_in_rw), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_rw(b_out_rw),
        .out_data(b_out_data), .occupancy(b_occ));

    pipe_stage_reg #(.CTRL_W(6), .RW_W(5), .DATA_W(32), .NUM_CH(3), .CLEAR_ON_FLUSH(0)) u_dut_c (
        .CLK(CLK), .reset(reset), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_rw(c_in_rw), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_rw(c_out_rw),
        .out_data(c_out_data), .occupancy(c_occ));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_send(input logic [5:0] ctrl);
        a_in_valid = 1'b1;
        a_in_ctrl  = ctrl;
        a_in_rw    = ctrl[4:0];
        a_in_data  = {64'h0, 32'hA000_0000 | 32'(ctrl)};
    endtask

    // Reference model for instance B: FIFO contents of the stage
    logic [74:0] q[$];
    logic [74:0] beat;
    bit          zeroed;
    bit          m_in_fire, m_out_fire;
    int          vthr, rthr;

    initial begin
        reset = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0; a_in_rw = 0; a_in_data = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0; b_in_rw = 0; b_in_data = 0;
        c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_ctrl = 0; c_in_rw = 0; c_in_data = 0;

        // 1: reset held with a beat offered, nothing may be accepted
        a_in_valid = 1'b1; a_in_ctrl = 6'h3F; a_in_rw = 5'h1F; a_in_data = {3{32'h1234_5678}};
        tick();
        tick();
        chk("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        chk("rst_out_ctrl",  128'(a_out_ctrl),  128'(6'h00));
        chk("rst_occ",       128'(a_occ),       128'(2'd0));
        chk("rst_in_ready",  128'(a_in_ready),  128'(1'b1));
        chk("rst_out_data",  128'(a_out_data),  128'(96'h0));
        reset = 1'b1;
        tick();
        chk("rel_out_valid", 128'(a_out_valid), 128'(1'b1));
        chk("rel_out_ctrl",  128'(a_out_ctrl),  128'(6'h3F));
        chk("rel_out_data",  128'(a_out_data),  128'({3{32'h1234_5678}}));
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("drain_valid", 128'(a_out_valid), 128'(1'b0));
        chk("drain_ctrl",  128'(a_out_ctrl),  128'(6'h00));

        // 2: back-to-back streaming with 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            a_send(6'(i));
            tick();
            chk("stream_valid", 128'(a_out_valid), 128'(1'b1));
            chk("stream_ctrl",  128'(a_out_ctrl),  128'(6'(i)));
            chk("stream_data",  128'(a_out_data[31:0]), 128'(32'hA000_0000 + 32'(i)));
            chk("stream_occ",   128'(a_occ), 128'(2'd1));
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 128'(a_out_valid), 128'(1'b0));

        // 3: backpressure fills main and skid, third beat waits upstream
        a_out_ready = 1'b0;
        a_send(6'd1);
        tick();
        chk("bp1_occ", 128'(a_occ), 128'(2'd1));
        chk("bp1_rdy", 128'(a_in_ready), 128'(1'b1));
        a_send(6'd2);
        tick();
        chk("bp2_occ", 128'(a_occ), 128'(2'd2));
        chk("bp2_rdy", 128'(a_in_ready), 128'(1'b0));
        chk("bp2_ctrl", 128'(a_out_ctrl), 128'(6'd1));
        a_send(6'd3);
        tick();
        chk("bp3_occ", 128'(a_occ), 128'(2'd2));
        chk("bp3_ctrl_stable", 128'(a_out_ctrl), 128'(6'd1));
        chk("bp3_data_stable", 128'(a_out_data[31:0]), 128'(32'hA000_0001));
        a_out_ready = 1'b1;
        tick();
        chk("bp_out2", 128'(a_out_ctrl), 128'(6'd2));
        chk("bp_out2_occ", 128'(a_occ), 128'(2'd1));
        tick();
        chk("bp_out3", 128'(a_out_ctrl), 128'(6'd3));
        a_in_valid = 1'b0;
        tick();
        chk("bp_empty", 128'(a_out_valid), 128'(1'b0));

        // 4: flush while FULL with out_fire and a beat offered
        a_out_ready = 1'b0;
        a_send(6'd4);
        tick();
        a_send(6'd5);
        tick();
        chk("fl_full_occ", 128'(a_occ), 128'(2'd2));
        a_flush = 1'b1; a_out_ready = 1'b1; a_send(6'd6);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_valid", 128'(a_out_valid), 128'(1'b0));
        chk("fl_ctrl",  128'(a_out_ctrl),  128'(6'd0));
        chk("fl_occ",   128'(a_occ),       128'(2'd0));
        chk("fl_rdy",   128'(a_in_ready),  128'(1'b1));
        chk("fl_data",  128'(a_out_data),  128'(96'h0));
        chk("fl_rw",    128'(a_out_rw),    128'(5'h0));
        // flush in HALF with coincident in_fire and out_fire
        a_send(6'd7);
        tick();
        a_flush = 1'b1; a_send(6'd8);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl_no_stale", 128'(a_out_valid), 128'(1'b0));
            tick();
        end

        // reset mid-transfer drops everything
        a_out_ready = 1'b0;
        a_send(6'd9);
        tick();
        a_send(6'd10);
        tick();
        a_in_valid = 1'b0;
        reset = 1'b0; a_flush = 1'b1;
        tick();
        reset = 1'b1; a_flush = 1'b0;
        chk("midrst_occ",   128'(a_occ),       128'(2'd0));
        chk("midrst_valid", 128'(a_out_valid), 128'(1'b0));
        chk("midrst_data",  128'(a_out_data),  128'(96'h0));
        a_out_ready = 1'b1;
        tick();
        chk("midrst_after", 128'(a_out_valid), 128'(1'b0));

        // 5: flush with payload retention
        c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_ctrl = 6'h2A; c_in_rw = 5'd17;
        c_in_data = {64'h0, 32'hDEAD_BEEF};
        tick();
        c_in_valid = 1'b0;
        chk("keep_pre_data", 128'(c_out_data[31:0]), 128'(32'hDEAD_BEEF));
        c_flush = 1'b1;
        tick();
        c_flush = 1'b0;
        chk("keep_valid", 128'(c_out_valid), 128'(1'b0));
        chk("keep_ctrl",  128'(c_out_ctrl),  128'(6'h0));
        chk("keep_data",  128'(c_out_data[31:0]), 128'(32'hDEAD_BEEF));
        chk("keep_rw",    128'(c_out_rw),    128'(5'd17));

        // 6: random traffic on the wide instance against a FIFO model
        zeroed = 1'b1;
        vthr = 50; rthr = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 1000 == 0) begin
                vthr = $urandom_range(15, 95);
                rthr = $urandom_range(15, 95);
            end
            b_in_valid  = ($urandom_range(0, 99) < vthr);
            b_out_ready = ($urandom_range(0, 99) < rthr);
            b_flush     = ($urandom_range(0, 63) == 0);
            b_in_ctrl   = 6'($urandom);
            b_in_rw     = 5'($urandom);
            b_in_data   = {$urandom, $urandom};
            beat        = {b_in_ctrl, b_in_rw, b_in_data};
            m_in_fire   = b_in_valid && (q.size() < 2);
            m_out_fire  = b_out_ready && (q.size() > 0);
            tick();
            if (b_flush) begin
                q.delete();
                zeroed = 1'b1;
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) begin
                    q.push_back(beat);
                    zeroed = 1'b0;
                end
            end
            chk("rnd_valid", 128'(b_out_valid), 128'(q.size() > 0));
            chk("rnd_occ",   128'(b_occ),       128'(q.size()));
            chk("rnd_rdy",   128'(b_in_ready),  128'(q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_head", 128'({b_out_ctrl, b_out_rw, b_out_data}), 128'(q[0]));
            end else begin
                chk("rnd_bubble_ctrl", 128'(b_out_ctrl), 128'(6'h0));
                if (zeroed) chk("rnd_flush_payload", 128'({b_out_rw, b_out_data}), 128'(69'h0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
